// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver, 5..9 data bits, optional parity,
// 1/2 stop bits, valid/ready holding register. Break detect: UART_RX_BREAK_EN.
module uart_rx_param #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun_err,
`ifdef UART_RX_BREAK_EN
   output logic                 break_det,
`endif
   output logic                 busy
);

   localparam int BAUD_OS = BAUD * OVERSAMPLE;
   localparam int DIV = (CLK_FREQ + BAUD_OS / 2) / BAUD_OS;
   localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int SW = $clog2(OVERSAMPLE);

   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
   localparam bit            HAS_PAR   = (PARITY != 0);
   localparam bit            PAR_ODD   = (PARITY == 1);

   if (DIV < 2) begin : g_bad_div
      $error("uart_rx_param: clock too slow for BAUD*OVERSAMPLE");
   end
   if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
      $error("uart_rx_param: OVERSAMPLE must be even and >= 8");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_dbits
      $error("uart_rx_param: DATA_BITS must be 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_par
      $error("uart_rx_param: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_rx_param: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_PAR   = 3'd3,
      S_STOP  = 3'd4
`ifdef UART_RX_BREAK_EN
      ,
      S_BRK   = 3'd5
`endif
   } state_t;

   state_t state;
   state_t state_nxt;

   logic                 sync_1;
   logic                 sync_rx;
   logic                 prev_rx;
   logic                 fall;

   logic [DW-1:0]        div_cnt;
   logic                 tick;
   logic [SW-1:0]        samp_cnt;
   logic                 half_hit;
   logic                 full_hit;
   logic [3:0]           bit_cnt;

   logic                 samp_clr;
   logic                 data_smp;
   logic                 par_smp;
   logic                 stop_smp;
   logic                 done;

   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 stop_low;
   logic                 frm_now;
   logic                 par_now;
   logic                 word_in;

`ifdef UART_RX_BREAK_EN
   logic                 first_low;
   logic                 first_now;
   logic                 brk;
`endif

   // Two-stage synchroniser plus one history flop for edge detection.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_1  <= 1'b1;
         sync_rx <= 1'b1;
         prev_rx <= 1'b1;
      end else begin
         sync_1  <= rx;
         sync_rx <= sync_1;
         prev_rx <= sync_rx;
      end
   end

   assign fall = prev_rx & ~sync_rx;

   // Oversample tick divider; parked at zero while idle so a start edge
   // always begins a fresh tick period.
   always_ff @(posedge clk) begin
      if (!rst) begin
         div_cnt <= '0;
      end else if (state == S_IDLE || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

   assign tick     = (div_cnt == DIV_LAST);
   assign half_hit = tick && (samp_cnt == HALF_LAST);
   assign full_hit = tick && (samp_cnt == FULL_LAST);

   // Ticks elapsed inside the current bit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         samp_cnt <= '0;
      end else if (state == S_IDLE || samp_clr) begin
         samp_cnt <= '0;
      end else if (tick) begin
         samp_cnt <= samp_cnt + SW'(1);
      end
   end

   // Bits sampled in the current state; restarts on every state change.
   always_ff @(posedge clk) begin
      if (!rst) begin
         bit_cnt <= '0;
      end else if (state_nxt != state) begin
         bit_cnt <= '0;
      end else if (data_smp || stop_smp) begin
         bit_cnt <= bit_cnt + 4'd1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (fall) begin
               state_nxt = S_START;
            end
         end
         S_START: begin
            if (half_hit) begin
               state_nxt = sync_rx ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (full_hit && bit_cnt == DATA_LAST) begin
               state_nxt = HAS_PAR ? S_PAR : S_STOP;
            end
         end
         S_PAR: begin
            if (full_hit) begin
               state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (done) begin
`ifdef UART_RX_BREAK_EN
               state_nxt = brk ? S_BRK : S_IDLE;
`else
               state_nxt = S_IDLE;
`endif
            end
         end
`ifdef UART_RX_BREAK_EN
         S_BRK: begin
            if (sync_rx) begin
               state_nxt = S_IDLE;
            end
         end
`endif
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // FSM outputs: sample strobes and frame completion.
   always_comb begin
      samp_clr = 1'b0;
      data_smp = 1'b0;
      par_smp  = 1'b0;
      stop_smp = 1'b0;
      done     = 1'b0;
      busy     = (state != S_IDLE);
      unique case (state)
         S_START: begin
            samp_clr = half_hit;
         end
         S_DATA: begin
            samp_clr = full_hit;
            data_smp = full_hit;
         end
         S_PAR: begin
            samp_clr = full_hit;
            par_smp  = full_hit;
         end
         S_STOP: begin
            samp_clr = full_hit;
            stop_smp = full_hit;
            done     = full_hit && (bit_cnt == STOP_LAST);
         end
         default: begin
            samp_clr = 1'b0;
         end
      endcase
   end

   // Data, parity and stop-bit capture (LSB arrives first).
   always_ff @(posedge clk) begin
      if (!rst) begin
         shreg    <= '0;
         par_bit  <= 1'b0;
         stop_low <= 1'b0;
      end else begin
         if (data_smp) begin
            shreg <= {sync_rx, shreg[DATA_BITS-1:1]};
         end
         if (par_smp) begin
            par_bit <= sync_rx;
         end
         if (stop_smp) begin
            stop_low <= (bit_cnt == 4'd0) ? ~sync_rx
                                          : (stop_low | ~sync_rx);
         end
      end
   end

   // Flags of the completing frame include the stop sample taken now.
   assign frm_now = ~sync_rx | (stop_low & (bit_cnt != 4'd0));
   assign par_now = HAS_PAR & ((^shreg ^ par_bit) != PAR_ODD);

`ifdef UART_RX_BREAK_EN
   // First stop sample, kept for the break test on two-stop frames.
   always_ff @(posedge clk) begin
      if (!rst) begin
         first_low <= 1'b0;
      end else if (stop_smp && bit_cnt == 4'd0) begin
         first_low <= ~sync_rx;
      end
   end

   assign first_now = (bit_cnt == 4'd0) ? ~sync_rx : first_low;
   assign brk       = (shreg == '0) & (!HAS_PAR | ~par_bit) & first_now;
   assign word_in   = done & ~brk;

   // One-cycle break indication instead of delivering a word.
   always_ff @(posedge clk) begin
      if (!rst) begin
         break_det <= 1'b0;
      end else begin
         break_det <= done & brk;
      end
   end
`else
   assign word_in = done;
`endif

   // Holding register: load when empty or drained this cycle, else overrun.
   always_ff @(posedge clk) begin
      if (!rst) begin
         data_out    <= '0;
         data_valid  <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         overrun_err <= 1'b0;
         if (word_in && (!data_valid || data_ready)) begin
            data_out   <= shreg;
            data_valid <= 1'b1;
            parity_err <= par_now;
            frame_err  <= frm_now;
         end else if (word_in) begin
            overrun_err <= 1'b1;
         end else if (data_valid && data_ready) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: 8N1 and 7E2 receivers driven with directed and random
// frames, checked against a frame-level reference model.
module tb_uart_rx_param;

   localparam int CLK_FREQ = 1_600_000;
   localparam int BAUD     = 10_000;
   localparam int OS       = 16;
   localparam int BIT_CLK  = 160;

   typedef struct packed {
      logic       word;
      logic [8:0] data;
      logic       pe;
      logic       fe;
      logic       brk;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx   [2];
   logic       rdy  [2];
   logic [7:0] d8;
   logic [6:0] d7;
   logic       vld  [2];
   logic       perr [2];
   logic       ferr [2];
   logic       ovr  [2];
   logic       bsy  [2];
`ifdef UART_RX_BREAK_EN
   logic       brk  [2];
   int         brk_cnt [2] = '{0, 0};
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int start_cyc [2] = '{0, 0};
   int rise_cyc  [2] = '{0, 0};
   int ovr_cnt   [2] = '{0, 0};
   logic pv      [2] = '{1'b0, 1'b0};

   always #5 clk = ~clk;

   uart_rx_param #(
      .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
      .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
   ) u_dut8 (
      .clk(clk), .rst(rst), .rx(rx[0]),
      .data_out(d8), .data_valid(vld[0]), .data_ready(rdy[0]),
      .parity_err(perr[0]), .frame_err(ferr[0]),
      .overrun_err(ovr[0]),
`ifdef UART_RX_BREAK_EN
      .break_det(brk[0]),
`endif
      .busy(bsy[0])
   );

   uart_rx_param #(
      .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
      .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
   ) u_dut7 (
      .clk(clk), .rst(rst), .rx(rx[1]),
      .data_out(d7), .data_valid(vld[1]), .data_ready(rdy[1]),
      .parity_err(perr[1]), .frame_err(ferr[1]),
      .overrun_err(ovr[1]),
`ifdef UART_RX_BREAK_EN
      .break_det(brk[1]),
`endif
      .busy(bsy[1])
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (vld[u] && !pv[u]) rise_cyc[u] = cyc;
         pv[u] = vld[u];
         if (ovr[u]) ovr_cnt[u]++;
`ifdef UART_RX_BREAK_EN
         if (brk[u]) brk_cnt[u]++;
`endif
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic int nbits(int u);
      return (u == 0) ? 8 : 7;
   endfunction

   function automatic int npar(int u);
      return (u == 0) ? 0 : 1;
   endfunction

   function automatic int nstop(int u);
      return (u == 0) ? 1 : 2;
   endfunction

   function automatic logic [8:0] dat(int u);
      return (u == 0) ? {1'b0, d8} : {2'b00, d7};
   endfunction

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Frame-level reference: what the receiver must report for one frame.
   function automatic exp_t model(int u, logic [8:0] d, logic pb,
                                  logic [1:0] stp);
      exp_t e;
      int   ones;
      logic [8:0] mask;
      mask   = (9'd1 << nbits(u)) - 9'd1;
      e.data = d & mask;
      ones   = $countones(e.data);
      if (npar(u) != 0) ones += int'(pb);
      e.pe   = (u == 1) && ((ones % 2) != 0);
      e.fe   = !stp[0] || (nstop(u) == 2 && !stp[1]);
      e.brk  = 1'b0;
`ifdef UART_RX_BREAK_EN
      e.brk  = (e.data == 9'd0) && (npar(u) == 0 || !pb) && !stp[0];
`endif
      e.word = !e.brk;
      return e;
   endfunction

   task automatic drive_bit(int u, logic v);
      rx[u] = v;
      repeat (BIT_CLK) @(negedge clk);
   endtask

   task automatic send_frame(int u, logic [8:0] d, logic pb,
                             logic [1:0] stp);
      start_cyc[u] = cyc;
      drive_bit(u, 1'b0);
      for (int i = 0; i < nbits(u); i++) drive_bit(u, d[i]);
      if (npar(u) != 0) drive_bit(u, pb);
      for (int i = 0; i < nstop(u); i++) drive_bit(u, stp[i]);
      rx[u] = 1'b1;
   endtask

   task automatic expect_frame(int u, exp_t e, bit chk_lat, string tag);
      int t;
      int lat;
      int lo;
      t = 0;
      while (vld[u] !== 1'b1 && t < 40) begin
         @(negedge clk);
         t++;
      end
      check({tag, "/valid"}, 32'(vld[u]), 32'(1));
      check({tag, "/data"}, 32'(dat(u)), 32'(e.data));
      check({tag, "/parity_err"}, 32'(perr[u]), 32'(e.pe));
      check({tag, "/frame_err"}, 32'(ferr[u]), 32'(e.fe));
      if (chk_lat) begin
         lat = rise_cyc[u] - start_cyc[u];
         lo  = BIT_CLK * (nbits(u) + npar(u) + nstop(u)) + BIT_CLK / 2;
         check({tag, "/latency_in_window"},
               32'((lat >= lo && lat <= lo + 8) ? 1 : 0), 32'(1));
      end
   endtask

   task automatic accept(int u, string tag);
      rdy[u] = 1'b1;
      @(negedge clk);
      rdy[u] = 1'b0;
      check({tag, "/acc_valid"}, 32'(vld[u]), 32'(0));
      check({tag, "/acc_data"}, 32'(dat(u)), 32'(0));
      check({tag, "/acc_flags"}, 32'({perr[u], ferr[u]}), 32'(0));
   endtask

   task automatic check_idle(int u, string tag);
      check({tag, "/data"}, 32'(dat(u)), 32'(0));
      check({tag, "/valid"}, 32'(vld[u]), 32'(0));
      check({tag, "/parity_err"}, 32'(perr[u]), 32'(0));
      check({tag, "/frame_err"}, 32'(ferr[u]), 32'(0));
      check({tag, "/overrun"}, 32'(ovr[u]), 32'(0));
      check({tag, "/busy"}, 32'(bsy[u]), 32'(0));
   endtask

   exp_t       e;
   int         lat8;
   int         s1;
   int         o0;
   int         u;
   logic [8:0] d;
   logic       pb;
   logic [1:0] stp;
`ifdef UART_RX_BREAK_EN
   int         b0;
`endif

   initial begin
      rx[0] = 1'b1;
      rx[1] = 1'b1;
      rdy[0] = 1'b0;
      rdy[1] = 1'b0;
      repeat (5) @(negedge clk);
      check_idle(0, "reset8");
      check_idle(1, "reset7");
      rst = 1'b1;
      repeat (20) @(negedge clk);

      e = model(0, 9'h0A5, 1'b0, 2'b11);
      send_frame(0, 9'h0A5, 1'b0, 2'b11);
      expect_frame(0, e, 1'b1, "a5");
      lat8 = rise_cyc[0] - start_cyc[0];
      accept(0, "a5");

      rx[0] = 1'b0;
      repeat (20) @(negedge clk);
      check("false/busy_high", 32'(bsy[0]), 32'(1));
      repeat (20) @(negedge clk);
      rx[0] = 1'b1;
      repeat (300) @(negedge clk);
      check("false/valid", 32'(vld[0]), 32'(0));
      check("false/busy_low", 32'(bsy[0]), 32'(0));

      e = model(1, 9'h003, 1'b1, 2'b11);
      send_frame(1, 9'h003, 1'b1, 2'b11);
      expect_frame(1, e, 1'b1, "par03");
      accept(1, "par03");

      e = model(0, 9'h03C, 1'b0, 2'b10);
      send_frame(0, 9'h03C, 1'b0, 2'b10);
      expect_frame(0, e, 1'b1, "frm3c");
      accept(0, "frm3c");
      repeat (10) @(negedge clk);

`ifdef UART_RX_BREAK_EN
      b0 = brk_cnt[0];
      send_frame(0, 9'h000, 1'b0, 2'b10);
      repeat (10) @(negedge clk);
      check("brk/valid", 32'(vld[0]), 32'(0));
      check("brk/pulses", 32'(brk_cnt[0] - b0), 32'(1));
`endif

      o0 = ovr_cnt[0];
      send_frame(0, 9'h011, 1'b0, 2'b11);
      send_frame(0, 9'h022, 1'b0, 2'b11);
      repeat (2) @(negedge clk);
      check("ovr/data_kept", 32'(dat(0)), 32'h11);
      check("ovr/valid", 32'(vld[0]), 32'(1));
      check("ovr/pulses", 32'(ovr_cnt[0] - o0), 32'(1));
      accept(0, "ovr");

      o0 = ovr_cnt[0];
      s1 = cyc;
      fork
         begin
            send_frame(0, 9'h011, 1'b0, 2'b11);
            send_frame(0, 9'h022, 1'b0, 2'b11);
         end
         begin
            while (cyc < s1 + 10 * BIT_CLK + lat8 - 1) @(negedge clk);
            rdy[0] = 1'b1;
            @(negedge clk);
            rdy[0] = 1'b0;
         end
      join
      repeat (2) @(negedge clk);
      check("rdy2/data_new", 32'(dat(0)), 32'h22);
      check("rdy2/valid", 32'(vld[0]), 32'(1));
      check("rdy2/no_overrun", 32'(ovr_cnt[0] - o0), 32'(0));

      fork
         send_frame(0, 9'h0F0, 1'b0, 2'b11);
         begin
            repeat (5 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            check_idle(0, "midrst");
            rst = 1'b1;
         end
      join
      repeat (10) @(negedge clk);
      check("midrst/no_word", 32'(vld[0]), 32'(0));
      e = model(0, 9'h05A, 1'b0, 2'b11);
      send_frame(0, 9'h05A, 1'b0, 2'b11);
      expect_frame(0, e, 1'b1, "after_rst");
      accept(0, "after_rst");

      for (int k = 0; k < 20; k++) begin
         u   = k % 2;
         d   = 9'($urandom);
         pb  = (^d[6:0]) ^ ($urandom_range(0, 3) == 0);
         stp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2))
                                           : 2'b11;
         if (k == 6) begin
            d   = 9'd0;
            stp = 2'b10;
         end
         repeat ($urandom_range(4, 60)) @(negedge clk);
         e = model(u, d, pb, stp);
`ifdef UART_RX_BREAK_EN
         b0 = brk_cnt[u];
`endif
         send_frame(u, d, pb, stp);
         if (e.word) begin
            expect_frame(u, e, 1'b1, $sformatf("rnd%0d", k));
            accept(u, $sformatf("rnd%0d", k));
         end else begin
            repeat (10) @(negedge clk);
            check($sformatf("rnd%0d/brk_valid", k), 32'(vld[u]), 32'(0));
`ifdef UART_RX_BREAK_EN
            check($sformatf("rnd%0d/brk_pulse", k),
                  32'(brk_cnt[u] - b0), 32'(1));
`endif
         end
      end

      repeat (20) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
